// File: rtl/txuart_arbiter_if.sv
// Requester and transmitter signals of the shared UART TX arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/transmitter side.
interface txuart_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   i_req_last;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [NUM_REQ-1:0]   o_grant;
  logic                 o_tx_enable;
  logic [7:0]           o_tx_data;
  logic                 i_tx_idle;
  logic                 o_busy;
  logic                 o_err_timeout;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_idle,
    input  o_req_ready, o_grant, o_tx_enable, o_tx_data, o_busy, o_err_timeout
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_idle,
    output o_req_ready, o_grant, o_tx_enable, o_tx_data, o_busy, o_err_timeout
  );
endinterface

// File: rtl/txuart_arbiter.sv
// Round-robin arbiter sharing one byte-serial UART transmitter between NUM_REQ requesters,
// with per-message locking and an acknowledge timeout on the transmitter's idle flag.
module txuart_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input logic               i_clk,
  input logic               i_rst_n,
  txuart_arbiter_if.slave   bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW-1:0] PTR_RST  = PW'(NUM_REQ - 1);
  localparam logic [7:0]    ACK_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {ARB, SEND, WAIT_ACK, WAIT_DONE} state_e;

  state_e               state_q, state_d;
  logic                 lock_q, lock_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]           ack_cnt_q, ack_cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           tx_data_q, tx_data_d;

  logic [NUM_REQ-1:0]   cand;
  logic                 found;
  logic [PW-1:0]        pick;
  logic [NUM_REQ-1:0]   pick_oh;
  logic                 accept;
  logic                 ack_expired;

  // While locked only the owner may compete; the search starts just past the last winner.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_b;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    idx   = 0;
    idx_b = '0;
    cand  = lock_q ? (bus.i_req_valid & grant_q) : bus.i_req_valid;
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_b = PW'(idx);
      if (!found && cand[idx_b]) begin
        found = 1'b1;
        pick  = idx_b;
      end
    end
    pick_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
  end

  // Reset gates the accept strobe so no byte is taken while the block is held in reset.
  assign accept      = i_rst_n && (state_q == ARB) && found && bus.i_tx_idle;
  assign ack_expired = bus.i_tx_idle && (ack_cnt_q == ACK_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ARB;
      lock_q    <= 1'b0;
      rr_ptr_q  <= PTR_RST;
      ack_cnt_q <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      state_q   <= state_d;
      lock_q    <= lock_d;
      rr_ptr_q  <= rr_ptr_d;
      ack_cnt_q <= ack_cnt_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    rr_ptr_d  = rr_ptr_q;
    ack_cnt_d = ack_cnt_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    case (state_q)
      ARB: begin
        if (accept) begin
          tx_data_d = bus.i_req_data[{pick, 3'b000} +: 8];
          rr_ptr_d  = pick;
          grant_d   = pick_oh;
          lock_d    = !bus.i_req_last[pick];
          state_d   = SEND;
        end
      end
      SEND: begin
        ack_cnt_d = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!bus.i_tx_idle) begin
          state_d = WAIT_DONE;
        end else if (ack_expired) begin
          lock_d  = 1'b0;
          grant_d = '0;
          state_d = ARB;
        end else if (ack_cnt_q != 8'hFF) begin
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (bus.i_tx_idle) begin
          state_d = ARB;
          if (!lock_q) grant_d = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    bus.o_req_ready   = '0;
    bus.o_tx_enable   = 1'b0;
    bus.o_err_timeout = 1'b0;
    bus.o_busy        = (state_q != ARB) || lock_q;
    case (state_q)
      ARB:      if (accept) bus.o_req_ready = pick_oh;
      SEND:     bus.o_tx_enable = 1'b1;
      WAIT_ACK: bus.o_err_timeout = ack_expired;
      default:  ;
    endcase
  end

  assign bus.o_grant   = grant_q;
  assign bus.o_tx_data = tx_data_q;

endmodule

// File: tb/tb_txuart_arbiter.sv
// Self-checking bench for txuart_arbiter: queued requester stimulus, a registered transmitter model
// and a scoreboard of expected (requester, byte) pairs checked on every o_tx_enable.
module tb_txuart_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int ACK_TIMEOUT = 15;
  localparam int TX_LEN      = 6;

  typedef struct {
    int         gap;
    bit         last;
    logic [7:0] data;
  } item_t;

  typedef struct {
    int         req;
    logic [7:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  txuart_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  txuart_arbiter #(.NUM_REQ(NUM_REQ), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  item_t src_q[NUM_REQ][$];
  exp_t  exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_en  = 0;
  int    cyc   = 0;

  // Transmitter model: busy TX_LEN cycles after enable, idle flag registered (one cycle lag).
  bit   dead      = 1'b0;
  int   tx_cnt    = 0;
  logic tx_idle_r = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_tx_enable) tx_cnt <= TX_LEN;
    else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    tx_idle_r <= (tx_cnt == 0);
  end

  assign bus.i_tx_idle = dead ? 1'b1 : tx_idle_r;

  // Requester driver: presents the head of each queue after its gap, holds it until accepted.
  initial begin
    logic [NUM_REQ-1:0]   v;
    logic [NUM_REQ-1:0]   l;
    logic [8*NUM_REQ-1:0] d;
    bit acc[NUM_REQ];
    bit started[NUM_REQ];
    int gap[NUM_REQ];
    for (int k = 0; k < NUM_REQ; k++) begin
      acc[k] = 1'b0; started[k] = 1'b0; gap[k] = 0;
    end
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    bus.i_req_data  = '0;
    forever begin
      @(negedge clk);
      v = '0; l = '0; d = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (acc[k]) begin
          void'(src_q[k].pop_front());
          started[k] = 1'b0;
          acc[k]     = 1'b0;
        end
        if (src_q[k].size() > 0) begin
          if (!started[k]) begin
            gap[k]     = src_q[k][0].gap;
            started[k] = 1'b1;
          end
          if (gap[k] > 0) gap[k] = gap[k] - 1;
          else begin
            v[k]       = 1'b1;
            l[k]       = src_q[k][0].last;
            d[8*k +: 8] = src_q[k][0].data;
          end
        end
      end
      bus.i_req_valid = v;
      bus.i_req_last  = l;
      bus.i_req_data  = d;
      #1;
      for (int k = 0; k < NUM_REQ; k++) acc[k] = v[k] && bus.o_req_ready[k];
    end
  end

  // Scoreboard monitor: every enable must match the next expected byte and owner.
  initial begin
    exp_t e;
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (bus.o_req_ready != '0) begin
        n_cmp++;
        if (!$onehot(bus.o_req_ready) || bus.i_tx_idle !== 1'b1) begin
          n_bad++;
          $display("FAIL accept_legal: ready=%b tx_idle=%b (need one-hot ready with idle=1)",
                   bus.o_req_ready, bus.i_tx_idle);
        end
      end
      if (bus.o_tx_enable === 1'b1) begin
        n_en++;
        n_cmp++;
        if (prev_en) begin
          n_bad++;
          $display("FAIL enable_pulse: enable high two cycles in a row at cycle %0d", cyc);
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: enable grant=%b data=%h with nothing expected",
                   bus.o_grant, bus.o_tx_data);
        end else begin
          e = exp_q.pop_front();
          n_cmp++;
          if (bus.o_tx_data !== e.data || bus.o_grant !== NUM_REQ'(1 << e.req)) begin
            n_bad++;
            $display("FAIL sb_byte: got grant=%b data=%h, expected grant=%b data=%h",
                     bus.o_grant, bus.o_tx_data, NUM_REQ'(1 << e.req), e.data);
          end
        end
      end
      prev_en = bus.o_tx_enable;
    end
  end

  task automatic push(input int req, input int gap, input bit last, input logic [7:0] data);
    item_t it;
    exp_t  e;
    it.gap = gap; it.last = last; it.data = data;
    src_q[req].push_back(it);
    e.req = req; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_quiet(input string name, input int budget);
    bit done;
    int pending;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #2;
      pending = exp_q.size();
      for (int k = 0; k < NUM_REQ; k++) pending += src_q[k].size();
      if (pending == 0 && bus.o_busy === 1'b0 && bus.i_tx_idle === 1'b1) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s_drain: %0d expected bytes outstanding, busy=%b after %0d cycles",
               name, exp_q.size(), bus.o_busy, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_req_ready, bus.o_grant, bus.o_tx_enable, bus.o_tx_data, bus.o_busy, bus.o_err_timeout}
        !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b grant=%b en=%b data=%h busy=%b err=%b, need all 0",
               bus.o_req_ready, bus.o_grant, bus.o_tx_enable, bus.o_tx_data, bus.o_busy,
               bus.o_err_timeout);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_grant !== '0 || bus.o_tx_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b grant=%b en=%b after release, need 0/0/0",
               bus.o_busy, bus.o_grant, bus.o_tx_enable);
    end
  endtask

  task automatic test_single();
    bit seen;
    seen = 1'b0;
    push(0, 0, 1'b1, 8'h55);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (bus.o_req_ready[0] === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL single_accept: ready[0] never rose, ready=%b", bus.o_req_ready);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (bus.o_tx_enable !== 1'b1 || bus.o_tx_data !== 8'h55 || bus.o_grant !== 4'b0001) begin
      n_bad++;
      $display("FAIL single_send: en=%b data=%h grant=%b, need 1/55/0001",
               bus.o_tx_enable, bus.o_tx_data, bus.o_grant);
    end
    for (int i = 0; i < 40 && bus.o_busy === 1'b1; i++) begin
      n_cmp++;
      if (bus.o_grant !== 4'b0001) begin
        n_bad++;
        $display("FAIL single_grant_hold: grant=%b while busy, need 0001", bus.o_grant);
      end
      @(negedge clk);
      #2;
    end
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_grant !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_done: busy=%b grant=%b, need 0/0000", bus.o_busy, bus.o_grant);
    end
    wait_quiet("single", 20);
  endtask

  task automatic test_round_robin();
    int en0;
    reset_dut();
    en0 = n_en;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NUM_REQ; k++) push(k, 0, 1'b1, 8'(8'hA0 + k));
    wait_quiet("rr", 200);
    n_cmp++;
    if (n_en - en0 !== 8) begin
      n_bad++;
      $display("FAIL rr_enable_count: %0d enables, need 8", n_en - en0);
    end
  endtask

  task automatic test_locked();
    bit seen;
    bit done;
    int pending;
    seen = 1'b0;
    done = 1'b0;
    push(2, 0,  1'b0, 8'h4F);
    push(2, 3,  1'b0, 8'h4B);
    push(2, 14, 1'b0, 8'h0D);
    push(2, 0,  1'b1, 8'h0A);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (bus.o_grant === 4'b0100) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL lock_first_grant: grant=%b, need 0100", bus.o_grant);
    end
    push(1, 0, 1'b1, 8'h31);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #2;
      if (src_q[2].size() > 0 && bus.i_req_valid[2] === 1'b0 && bus.o_grant === 4'b0100) begin
        n_cmp++;
        if (bus.o_req_ready !== 4'b0000 || bus.o_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL lock_gap: ready=%b busy=%b while owner idle, need 0000/1",
                   bus.o_req_ready, bus.o_busy);
        end
      end
      pending = exp_q.size();
      for (int k = 0; k < NUM_REQ; k++) pending += src_q[k].size();
      if (pending == 0 && bus.o_busy === 1'b0) done = 1'b1;
    end
    wait_quiet("lock", 40);
  endtask

  task automatic test_timeout();
    bit seen;
    int e_cyc;
    seen  = 1'b0;
    e_cyc = 0;
    dead  = 1'b1;
    push(3, 0, 1'b0, 8'h77);
    push(0, 0, 1'b1, 8'h10);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (bus.o_tx_enable === 1'b1) begin seen = 1'b1; e_cyc = cyc; end
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (bus.o_err_timeout === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || cyc - e_cyc !== ACK_TIMEOUT) begin
      n_bad++;
      $display("FAIL timeout_delay: err seen=%b after %0d cycles, need %0d",
               seen, cyc - e_cyc, ACK_TIMEOUT);
    end
    @(negedge clk);
    #2;
    n_cmp++;
    if (bus.o_grant !== 4'b0000 || bus.o_busy !== 1'b0 || bus.o_req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL timeout_release: grant=%b busy=%b ready=%b, need 0000/0/0001",
               bus.o_grant, bus.o_busy, bus.o_req_ready);
    end
    wait_quiet("timeout", 60);
    dead = 1'b0;
    repeat (TX_LEN + 4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    reset_dut();
    seen = 1'b0;
    push(1, 0, 1'b0, 8'h61);
    push(1, 0, 1'b0, 8'h62);
    src_q[1].push_back('{gap: 0, last: 1'b1, data: 8'h63});
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (bus.o_tx_enable === 1'b1 && bus.o_tx_data === 8'h62) seen = 1'b1;
    end
    for (int i = 0; i < 10 && bus.i_tx_idle === 1'b1; i++) @(negedge clk);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_req_ready, bus.o_grant, bus.o_tx_enable, bus.o_tx_data, bus.o_busy, bus.o_err_timeout}
        !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: ready=%b grant=%b en=%b data=%h busy=%b err=%b, need all 0",
               bus.o_req_ready, bus.o_grant, bus.o_tx_enable, bus.o_tx_data, bus.o_busy,
               bus.o_err_timeout);
    end
    push(0, 0, 1'b1, 8'h30);
    begin
      exp_t e;
      e.req = 1; e.data = 8'h63;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    n_cmp++;
    if (bus.i_tx_idle !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_tx_busy: tx_idle=%b at release, need 0", bus.i_tx_idle);
    end
    for (int i = 0; i < 30 && bus.i_tx_idle !== 1'b1; i++) begin
      @(negedge clk);
      #2;
      if (bus.i_tx_idle !== 1'b1) begin
        n_cmp++;
        if (bus.o_req_ready !== 4'b0000 || bus.o_tx_enable !== 1'b0) begin
          n_bad++;
          $display("FAIL midreset_hold: ready=%b en=%b while tx busy, need 0000/0",
                   bus.o_req_ready, bus.o_tx_enable);
        end
      end
    end
    wait_quiet("midreset", 80);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_locked();
    test_timeout();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
